axil_master_lite: RTL

- Single-outstanding AXI4-Lite initiator; drives the s00_axi_* slave port of wja_bus_lite (or any AXI4-Lite slave) from a simple command/response interface.
- Used by fabric-side sequencers and benches to read and write register-file slaves without the PS.
- Handles exactly one transaction at a time: write (AW+W, then B) or read (AR, then R).

---
 rtl/axil_master_lite.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/axil_master_lite.sv
// axil_master_lite: single-outstanding AXI4-Lite initiator driven by a simple
// command/response interface. One transaction at a time: write (AW+W, then B)
// or read (AR, then R). All outputs come straight from flops.
// Optional build macro AXIL_MASTER_TIMEOUT_EN adds a per-transaction cycle
// limit (TIMEOUT_CYCLES) that aborts a hung transaction with rsp_resp=2'b11.
module axil_master_lite #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    // Command / response interface
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    // AXI4-Lite master port
    output logic [ADDR_WIDTH-1:0] m00_axi_awaddr,
    output logic                  m00_axi_awvalid,
    input  logic                  m00_axi_awready,
    output logic [31:0]           m00_axi_wdata,
    output logic [3:0]            m00_axi_wstrb,
    output logic                  m00_axi_wvalid,
    input  logic                  m00_axi_wready,
    input  logic [1:0]            m00_axi_bresp,
    input  logic                  m00_axi_bvalid,
    output logic                  m00_axi_bready,
    output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_arready,
    input  logic [31:0]           m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWrite = 3'd1;
    localparam logic [2:0] StWresp = 3'd2;
    localparam logic [2:0] StRead  = 3'd3;
    localparam logic [2:0] StRdata = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic [2:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [31:0]           wdata_q,     wdata_d;
    logic [3:0]            wstrb_q,     wstrb_d;
    logic                  awvalid_q,   awvalid_d;
    logic                  wvalid_q,    wvalid_d;
    logic                  bready_q,    bready_d;
    logic                  arvalid_q,   arvalid_d;
    logic                  rready_q,    rready_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q,  rsp_resp_d;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy;
`endif

    // Next-state, handshake tracking and response capture
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        busy        = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
`ifdef AXIL_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrite;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRead;
                    end
                end
            end
            StWrite: begin
                // AW and W retire independently; B is awaited once both are gone.
                if (awvalid_q && m00_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m00_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StWresp;
                end
            end
            StWresp: begin
                if (m00_axi_bvalid && bready_q) begin
                    rsp_resp_d  = m00_axi_bresp;
                    rsp_rdata_d = 32'h0;
                    bready_d    = 1'b0;
                    state_d     = StDone;
                end
            end
            StRead: begin
                if (m00_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (m00_axi_rvalid && rready_q) begin
                    rsp_rdata_d = m00_axi_rdata;
                    rsp_resp_d  = m00_axi_rresp;
                    rready_d    = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                state_d   = StIdle;
            end
        endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
        busy = (state_q == StWrite) || (state_q == StWresp) ||
               (state_q == StRead)  || (state_q == StRdata);
        if (busy) begin
            cnt_d = cnt_q + CntW'(1);
            // Deliberate protocol abort: the slave is considered hung.
            if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_resp_d  = 2'b11;
                rsp_rdata_d = 32'hDEADBEEF;
                state_d     = StDone;
            end
        end
`endif

        // Registered so that neither depends on any input in the same cycle.
        cmd_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StDone);
    end

    // State and output registers; cmd_ready reads 0 while reset is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
`ifdef AXIL_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef AXIL_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_resp        = rsp_resp_q;
    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = wstrb_q;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;

endmodule
